// File: rtl/bc_pkg.sv
// bc_pkg: shared types and constants for code entry and the Bulls & Cows game FSM.
// Contents: digit geometry, entry FSM states, error reasons, the ordered digit-pair
// table walked by the repeat check, and a digit extraction helper.
package bc_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
    localparam logic [3:0] LAST_IDX = 4'd9;
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} entry_state_t;
    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_BCD    = 2'b01,
        ERR_REPEAT = 2'b10
    } err_kind_t;
    // Pair n (checked at idx 4+n): (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); element 0 is rightmost.
    localparam logic [5:0][1:0] PAIR_A = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [5:0][1:0] PAIR_B = {2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};
    function automatic logic [DIGIT_W-1:0] digit(input logic [CODE_W-1:0] c, input logic [1:0] i);
        return c[DIGIT_W*i +: DIGIT_W];
    endfunction
endpackage

// File: rtl/code_entry_if.sv
// code_entry_if: switch/button inputs and validated-code outputs of the code entry stage.
// Signals: code (raw switches), enter_button (raw push button), code_out (last accepted
// code), code_valid / code_error (one-cycle report pulses), err_kind (reject reason), busy.
// master: the side driving switches/button and consuming reports; slave: code_entry.
interface code_entry_if;
    logic [bc_pkg::CODE_W-1:0] code;
    logic                      enter_button;
    logic [bc_pkg::CODE_W-1:0] code_out;
    logic                      code_valid;
    logic                      code_error;
    logic [1:0]                err_kind;
    logic                      busy;
    modport master (
        output code, enter_button,
        input  code_out, code_valid, code_error, err_kind, busy
    );
    modport slave (
        input  code, enter_button,
        output code_out, code_valid, code_error, err_kind, busy
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button, debounces it and emits a rising-edge pulse.
// Ports: clock, reset (async, active-high), button (raw, asynchronous),
// press (one cycle high on each rising edge of the debounced level).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          s1, s2, level, level_d;
    logic [CW-1:0] cnt;
    // The level only flips after DEBOUNCE_CYCLES consecutive differing samples;
    // any agreement in between restarts the count, so short glitches are absorbed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= button;
            s2      <= s1;
            level_d <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign press = level & ~level_d;
endmodule

// File: rtl/code_entry.sv
// code_entry: captures the switch code on each debounced enter press and validates it
// one test per cycle (four BCD checks, then six pairwise repeat checks) before
// reporting a valid code or an error reason to the game FSM.
// Ports: clock, reset (async, active-high), bus (code_entry_if.slave).
module code_entry
    import bc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    code_entry_if.slave       bus
);
    logic              press;
    logic [CODE_W-1:0] code_s1, code_s2;
    logic [CODE_W-1:0] snap, snap_n;
    logic [CODE_W-1:0] out_q, out_n;
    logic [3:0]        idx, idx_n;
    logic              valid_q, valid_n, error_q, error_n;
    err_kind_t         kind_q, kind_n;
    entry_state_t      state, state_n;
    logic [2:0]        pair;
    logic              bcd_fail, rep_fail;
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock  (clock),
        .reset  (reset),
        .button (bus.enter_button),
        .press  (press)
    );
    // idx 0-3 test digit idx for BCD, idx 4-9 test pair idx-4 for a repeat.
    assign pair     = (idx >= 4'd4) ? 3'(idx - 4'd4) : 3'd0;
    assign bcd_fail = (idx < 4'd4) && (digit(snap, idx[1:0]) > 4'd9);
    assign rep_fail = (idx >= 4'd4) && (digit(snap, PAIR_A[pair]) == digit(snap, PAIR_B[pair]));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_s1 <= '0;
            code_s2 <= '0;
            snap    <= '0;
            out_q   <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            kind_q  <= ERR_NONE;
            state   <= IDLE;
        end else begin
            code_s1 <= bus.code;
            code_s2 <= code_s1;
            snap    <= snap_n;
            out_q   <= out_n;
            idx     <= idx_n;
            valid_q <= valid_n;
            error_q <= error_n;
            kind_q  <= kind_n;
            state   <= state_n;
        end
    end
    // Report outputs are computed on the transition into REPORT and registered,
    // so they are high exactly for the single REPORT cycle.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        snap_n  = snap;
        out_n   = out_q;
        valid_n = 1'b0;
        error_n = 1'b0;
        kind_n  = ERR_NONE;
        case (state)
            IDLE: begin
                if (press) begin
                    snap_n  = code_s2;
                    idx_n   = 4'd0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                idx_n = idx + 4'd1;
                if (bcd_fail || rep_fail) begin
                    state_n = REPORT;
                    error_n = 1'b1;
                    kind_n  = bcd_fail ? ERR_BCD : ERR_REPEAT;
                end else if (idx == LAST_IDX) begin
                    state_n = REPORT;
                    valid_n = 1'b1;
                    out_n   = snap;
                end
            end
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.code_out   = out_q;
    assign bus.code_valid = valid_q;
    assign bus.code_error = error_q;
    assign bus.err_kind   = kind_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_code_entry.sv
// tb_code_entry: scoreboard bench for code_entry with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected report (type, code_out, err_kind, cycle); a negedge
// monitor pops and compares whenever code_valid or code_error is presented.
module tb_code_entry;
    typedef struct {
        logic        is_valid;
        logic [15:0] code;
        logic [1:0]  kind;
        int          cyc;
    } exp_t;
    logic   clock = 1'b0;
    logic   reset = 1'b1;
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     busy_cnt = 0;
    int     t0;
    exp_t   sb[$];
    code_entry_if bus();
    code_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic push(input logic v, input logic [15:0] c, input logic [1:0] k, input int at);
        exp_t e;
        e.is_valid = v;
        e.code     = c;
        e.kind     = k;
        e.cyc      = at;
        sb.push_back(e);
    endtask
    // Monitor: every report pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (bus.busy) busy_cnt++;
        if (bus.code_valid || bus.code_error) begin
            check("exclusive_pulses", 32'(bus.code_valid & bus.code_error), 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b kind=%0h code_out=%0h, expected no pulse (cycle %0d)",
                         bus.code_valid, bus.code_error, bus.err_kind, bus.code_out, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_is_valid", 32'(bus.code_valid), 32'(e.is_valid));
                check("pulse_code_out", 32'(bus.code_out), 32'(e.code));
                check("pulse_err_kind", 32'(bus.err_kind), 32'(e.kind));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end
    initial begin
        bus.code         = 16'h0000;
        bus.enter_button = 1'b0;
        #1;
        check("rst_code_out", 32'(bus.code_out), 32'd0);
        check("rst_valid", 32'(bus.code_valid), 32'd0);
        check("rst_error", 32'(bus.code_error), 32'd0);
        check("rst_kind", 32'(bus.err_kind), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        step(3);
        reset = 1'b0;
        step(3);
        // Valid code, button held 12 cycles: press event at t0+6, valid at t0+17.
        bus.code = 16'h1234;
        bus.enter_button = 1'b1;
        t0 = cyc;
        busy_cnt = 0;
        push(1'b1, 16'h1234, 2'b00, t0 + 17);
        step(12);
        bus.enter_button = 1'b0;
        step(20);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd11);
        check("t1_code_out", 32'(bus.code_out), 32'h1234);
        // Repeat: digits 0 and 3 are both 1, fails at idx 6 -> pulse at C+8.
        bus.code = 16'h1231;
        bus.enter_button = 1'b1;
        t0 = cyc;
        push(1'b0, 16'h1234, 2'b10, t0 + 6 + 8);
        step(8);
        bus.enter_button = 1'b0;
        step(16);
        // Non-BCD digit 1 (A), fails at idx 1 -> pulse at C+3.
        bus.code = 16'h12A4;
        bus.enter_button = 1'b1;
        t0 = cyc;
        push(1'b0, 16'h1234, 2'b01, t0 + 6 + 3);
        step(8);
        bus.enter_button = 1'b0;
        step(16);
        check("t3_code_out_kept", 32'(bus.code_out), 32'h1234);
        // Two-cycle glitch must never produce a press.
        busy_cnt = 0;
        bus.enter_button = 1'b1;
        step(2);
        bus.enter_button = 1'b0;
        step(20);
        check("t4_glitch_busy", 32'(busy_cnt), 32'd0);
        // Second debounced press lands during CHECK (idx 8) and is dropped; the
        // switches also change after the snapshot without affecting the result.
        bus.code = 16'h5678;
        bus.enter_button = 1'b1;
        t0 = cyc;
        push(1'b1, 16'h5678, 2'b00, t0 + 17);
        step(5);
        bus.enter_button = 1'b0;
        step(4);
        bus.enter_button = 1'b1;
        bus.code = 16'h1111;
        step(8);
        bus.enter_button = 1'b0;
        step(25);
        check("t5_code_out", 32'(bus.code_out), 32'h5678);
        // Reset at C+5 while checking: everything clears at once, no pulse afterwards.
        bus.code = 16'h1357;
        bus.enter_button = 1'b1;
        t0 = cyc;
        step(5);
        bus.enter_button = 1'b0;
        step(6);
        check("t6_busy_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_code_out", 32'(bus.code_out), 32'd0);
        check("t6_rst_valid", 32'(bus.code_valid), 32'd0);
        check("t6_rst_error", 32'(bus.code_error), 32'd0);
        check("t6_rst_kind", 32'(bus.err_kind), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        step(1);
        reset = 1'b0;
        step(25);
        check("t6_code_out_after", 32'(bus.code_out), 32'd0);
        // Button held across reset release: one capture DEBOUNCE_CYCLES+2 cycles later.
        reset = 1'b1;
        bus.code = 16'h9876;
        bus.enter_button = 1'b1;
        step(2);
        reset = 1'b0;
        t0 = cyc;
        push(1'b1, 16'h9876, 2'b00, t0 + 17);
        step(40);
        bus.enter_button = 1'b0;
        step(15);
        bus.enter_button = 1'b1;
        t0 = cyc;
        push(1'b1, 16'h9876, 2'b00, t0 + 17);
        step(6);
        bus.enter_button = 1'b0;
        step(20);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_busy", 32'(bus.busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
